noc_host_nic: RTL and testbench

- Host-side network interface for one node of the ring NoC; it is the endpoint at the far side of a router's host port.
- TX path: accepts messages from the local core (valid/ready), queues them, builds packets and injects them into the router via host_data_in / host_en under a pacing rule.
- RX path: captures packets delivered by the router, queues them and presents them to the core (valid/ready).
- Keeps saturating statistics counters for transmitted, received and dropped packets.

---
 rtl/noc_host_nic_pkg.sv | 27 ++
 rtl/noc_host_nic_if.sv | 36 +++
 rtl/noc_host_nic_fifo.sv | 47 ++++
 rtl/noc_host_nic.sv | 131 +++++++++++++
 tb/tb_noc_host_nic.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_host_nic_pkg.sv
// Shared definitions for the ring-NoC host interface: default widths,
// TX injection state encoding and small packet/counter helpers.
package noc_pkg;

   localparam int unsigned NOC_PACKET_SIZE = 8;
   localparam int unsigned NOC_ROUTER_BITS = 2;
   localparam int unsigned CNT_W           = 8;

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_SEND = 2'd1,
      TX_GAP  = 2'd2
   } tx_state_t;

   // Destination router field of a default-width packet.
   function automatic logic [NOC_ROUTER_BITS-1:0] pkt_dest(input logic [NOC_PACKET_SIZE-1:0] pkt);
      return pkt[NOC_PACKET_SIZE-1 -: NOC_ROUTER_BITS];
   endfunction

   // Saturating add of a small increment to a statistics counter.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input logic [1:0] inc);
      logic [CNT_W:0] sum;
      sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
      return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
   endfunction

endpackage

// File: rtl/noc_host_nic_if.sv
// Core-side and router-side signal bundle of the host NIC.
// slave: the NIC itself; master: the core/router environment driving it.
interface noc_host_nic_if
   import noc_pkg::*;
#(
   parameter int unsigned PACKET_SIZE = NOC_PACKET_SIZE,
   parameter int unsigned ROUTER_BITS = NOC_ROUTER_BITS
);
   logic                              core_tx_valid;
   logic                              core_tx_ready;
   logic [ROUTER_BITS-1:0]            core_tx_dest;
   logic [PACKET_SIZE-ROUTER_BITS-1:0] core_tx_payload;
   logic [PACKET_SIZE-1:0]            host_data_out;
   logic                              host_en;
   logic                              net_rx_valid;
   logic [PACKET_SIZE-1:0]            net_rx_data;
   logic                              core_rx_valid;
   logic                              core_rx_ready;
   logic [PACKET_SIZE-1:0]            core_rx_data;
   logic                              rx_overflow;
   logic [CNT_W-1:0]                  tx_count;
   logic [CNT_W-1:0]                  rx_count;
   logic [CNT_W-1:0]                  drop_count;

   modport slave (
      input  core_tx_valid, core_tx_dest, core_tx_payload, net_rx_valid, net_rx_data, core_rx_ready,
      output core_tx_ready, host_data_out, host_en, core_rx_valid, core_rx_data, rx_overflow,
             tx_count, rx_count, drop_count
   );

   modport master (
      output core_tx_valid, core_tx_dest, core_tx_payload, net_rx_valid, net_rx_data, core_rx_ready,
      input  core_tx_ready, host_data_out, host_en, core_rx_valid, core_rx_data, rx_overflow,
             tx_count, rx_count, drop_count
   );
endinterface

// File: rtl/noc_host_nic_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head is visible combinationally
// (forced to zero while empty). A push on a full FIFO succeeds only with a
// same-cycle pop.
module noc_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_count
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_count   = r_wr_ptr - r_rd_ptr;
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

   // Storage array write port.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

   // Read/write pointer advance.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end
endmodule

// File: rtl/noc_host_nic.sv
// Host-side NIC of one ring-NoC node: queued, paced TX injection into the
// router, queued RX delivery to the core, loopback for self-addressed
// traffic and saturating traffic statistics.
module noc_host_nic
   import noc_pkg::*;
#(
   parameter int unsigned PACKET_SIZE = NOC_PACKET_SIZE,
   parameter int unsigned ROUTER_BITS = NOC_ROUTER_BITS,
   parameter int unsigned ROUTER_ID   = 0,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned INJECT_GAP  = 1
) (
   input  logic          clk,
   input  logic          rst,
   noc_host_nic_if.slave bus
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned GW = $clog2(INJECT_GAP + 3);

   tx_state_t              r_state, w_next;
   logic [PACKET_SIZE-1:0] r_host_data;
   logic [GW-1:0]          r_gap;
   logic [CNT_W-1:0]       r_tx_cnt, r_rx_cnt, r_drop_cnt;
   logic                   r_ovf;

   logic [PACKET_SIZE-1:0] w_tx_pkt, w_tx_head, w_rx_wdata;
   logic                   w_loop, w_tx_ready, w_tx_acc, w_tx_push, w_lb_push;
   logic                   w_tx_full, w_tx_empty, w_tx_pop, w_gap_load, w_sent;
   logic                   w_rx_full, w_rx_empty, w_rx_pop, w_rx_space;
   logic                   w_net_push, w_net_drop;
   logic [AW:0]            w_unused_tx_level, w_unused_rx_level;

   assign w_tx_pkt   = {bus.core_tx_dest, bus.core_tx_payload};
   assign w_loop     = (bus.core_tx_dest == ROUTER_BITS'(ROUTER_ID));
   assign w_rx_pop   = !w_rx_empty && bus.core_rx_ready;
   assign w_rx_space = !w_rx_full || w_rx_pop;
   // Network delivery owns the RX write port; loopback waits via ready.
   assign w_tx_ready = w_loop ? (w_rx_space && !bus.net_rx_valid) : !w_tx_full;
   assign w_tx_acc   = bus.core_tx_valid && w_tx_ready;
   assign w_tx_push  = w_tx_acc && !w_loop;
   assign w_lb_push  = w_tx_acc && w_loop;
   assign w_net_push = bus.net_rx_valid && w_rx_space;
   assign w_net_drop = bus.net_rx_valid && !w_rx_space;
   assign w_rx_wdata = bus.net_rx_valid ? bus.net_rx_data : w_tx_pkt;

   noc_sync_fifo #(.WIDTH(PACKET_SIZE), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .rst(rst), .i_push(w_tx_push), .i_pop(w_tx_pop), .i_data(w_tx_pkt),
      .o_data(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty), .o_count(w_unused_tx_level)
   );

   noc_sync_fifo #(.WIDTH(PACKET_SIZE), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .rst(rst), .i_push(w_net_push || w_lb_push), .i_pop(w_rx_pop), .i_data(w_rx_wdata),
      .o_data(bus.core_rx_data), .o_full(w_rx_full), .o_empty(w_rx_empty), .o_count(w_unused_rx_level)
   );

   // TX injection state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= TX_IDLE;
      else      r_state <= w_next;
   end

   // TX next state and FIFO pop. The IDLE cycle that pops the next packet
   // serves as the last gap cycle, so GAP lasts INJECT_GAP-1 cycles and a
   // gap of 1 returns straight to IDLE.
   always_comb begin
      w_next     = r_state;
      w_tx_pop   = 1'b0;
      w_gap_load = 1'b0;
      w_sent     = 1'b0;
      case (r_state)
         TX_IDLE: begin
            if (!w_tx_empty) begin
               w_tx_pop = 1'b1;
               w_next   = TX_SEND;
            end
         end
         TX_SEND: begin
            w_sent = 1'b1;
            if (INJECT_GAP == 0) begin
               if (!w_tx_empty) w_tx_pop = 1'b1;
               else             w_next   = TX_IDLE;
            end else if (INJECT_GAP == 1) begin
               w_next = TX_IDLE;
            end else begin
               w_gap_load = 1'b1;
               w_next     = TX_GAP;
            end
         end
         TX_GAP: begin
            if (r_gap <= GW'(2)) w_next = TX_IDLE;
         end
         default: w_next = TX_IDLE;
      endcase
   end

   // Injected packet register and gap countdown.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_host_data <= '0;
         r_gap       <= '0;
      end else begin
         if (w_tx_pop) r_host_data <= w_tx_head;
         if (w_gap_load)             r_gap <= GW'(INJECT_GAP);
         else if (r_state == TX_GAP) r_gap <= r_gap - 1'b1;
      end
   end

   // Saturating statistics and sticky RX overflow flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tx_cnt   <= '0;
         r_rx_cnt   <= '0;
         r_drop_cnt <= '0;
         r_ovf      <= 1'b0;
      end else begin
         r_tx_cnt   <= sat_add(r_tx_cnt, {1'b0, w_sent} + {1'b0, w_lb_push});
         r_rx_cnt   <= sat_add(r_rx_cnt, {1'b0, w_net_push} + {1'b0, w_lb_push});
         r_drop_cnt <= sat_add(r_drop_cnt, {1'b0, w_net_drop});
         r_ovf      <= r_ovf | w_net_drop;
      end
   end

   assign bus.core_tx_ready = w_tx_ready;
   assign bus.host_en       = (r_state == TX_SEND);
   assign bus.host_data_out = r_host_data;
   assign bus.core_rx_valid = !w_rx_empty;
   assign bus.rx_overflow   = r_ovf;
   assign bus.tx_count      = r_tx_cnt;
   assign bus.rx_count      = r_rx_cnt;
   assign bus.drop_count    = r_drop_cnt;
endmodule

// File: tb/tb_noc_host_nic.sv
// Randomised scoreboard bench for noc_host_nic (ROUTER_ID=1, INJECT_GAP=2).
module tb_noc_host_nic;
   import noc_pkg::*;

   localparam int RID   = 1;
   localparam int GAP   = 2;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;

   noc_host_nic_if #(.PACKET_SIZE(8), .ROUTER_BITS(2)) bus ();

   noc_host_nic #(.PACKET_SIZE(8), .ROUTER_BITS(2), .ROUTER_ID(RID), .FIFO_DEPTH(DEPTH),
                  .INJECT_GAP(GAP)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [7:0] pkt;
   } inj_t;

   int         n_checks = 0;
   int         n_errors = 0;
   int         cyc = 0;
   bit         model_en = 1'b0;
   inj_t       txq[$];
   logic [7:0] rxq[$];
   int         last_inj;
   logic [7:0] last_pkt;
   int         m_tx, m_rx, m_drop;
   bit         m_ovf;
   int         last_acc_cyc, last_wait;
   int         stall_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int sat(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   function automatic void model_reset();
      txq.delete();
      rxq.delete();
      last_inj = -100;
      last_pkt = '0;
      m_tx = 0; m_rx = 0; m_drop = 0; m_ovf = 1'b0;
   endfunction

   function automatic logic [1:0] rand_net_dest();
      logic [1:0] d;
      do d = 2'($urandom_range(0, 3)); while (d == 2'(RID));
      return d;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (model_en && bus.core_tx_valid && !bus.core_tx_ready) stall_cnt++;
   end

   // Reference model and scoreboard: first compare this cycle's outputs,
   // then account for the effects of this cycle's inputs.
   always @(negedge clk) begin
      int         occ;
      bit         exp_en, pop, space, loop, exp_rdy;
      logic [7:0] pkt;
      inj_t       e;
      if (model_en) begin
         exp_en = (txq.size() > 0) && (txq[0].cyc == cyc);
         chk("host_en", 32'(bus.host_en), 32'(exp_en));
         if (exp_en) begin
            last_pkt = txq[0].pkt;
            void'(txq.pop_front());
         end
         chk("host_data_out", 32'(bus.host_data_out), 32'(last_pkt));
         chk("core_rx_valid", 32'(bus.core_rx_valid), 32'(rxq.size() > 0));
         chk("core_rx_data", 32'(bus.core_rx_data), (rxq.size() > 0) ? 32'(rxq[0]) : 32'd0);
         chk("tx_count", 32'(bus.tx_count), 32'(m_tx));
         chk("rx_count", 32'(bus.rx_count), 32'(m_rx));
         chk("drop_count", 32'(bus.drop_count), 32'(m_drop));
         chk("rx_overflow", 32'(bus.rx_overflow), 32'(m_ovf));

         occ = 0;
         foreach (txq[i]) if (txq[i].cyc > cyc) occ++;
         pkt     = {bus.core_tx_dest, bus.core_tx_payload};
         loop    = (pkt_dest(pkt) == 2'(RID));
         pop     = (rxq.size() > 0) && bus.core_rx_ready;
         space   = (rxq.size() < DEPTH) || pop;
         exp_rdy = loop ? (space && !bus.net_rx_valid) : (occ < DEPTH);
         chk("core_tx_ready", 32'(bus.core_tx_ready), 32'(exp_rdy));

         if (exp_en) m_tx = sat(m_tx + 1);
         if (pop) void'(rxq.pop_front());
         if (bus.net_rx_valid) begin
            if (space) begin
               rxq.push_back(bus.net_rx_data);
               m_rx = sat(m_rx + 1);
            end else begin
               m_drop = sat(m_drop + 1);
               m_ovf  = 1'b1;
            end
         end
         if (bus.core_tx_valid && exp_rdy) begin
            if (loop) begin
               rxq.push_back(pkt);
               m_rx = sat(m_rx + 1);
               m_tx = sat(m_tx + 1);
            end else begin
               e.cyc = (cyc + 2 > last_inj + 1 + GAP) ? cyc + 2 : last_inj + 1 + GAP;
               e.pkt = pkt;
               last_inj = e.cyc;
               txq.push_back(e);
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic tx_send(input logic [1:0] d, input logic [5:0] p);
      int n;
      bus.core_tx_dest    = d;
      bus.core_tx_payload = p;
      bus.core_tx_valid   = 1'b1;
      for (n = 0; n < 200; n++) begin
         @(negedge clk);
         if (bus.core_tx_ready) break;
      end
      chk("tx_accept_in_time", 32'(n < 200), 32'd1);
      last_acc_cyc = cyc;
      last_wait    = n;
      @(posedge clk);
      #1;
      bus.core_tx_valid = 1'b0;
   endtask

   task automatic wait_host_en(output int c);
      int n;
      for (n = 0; n < 60; n++) begin
         @(negedge clk);
         if (bus.host_en) break;
      end
      chk("host_en_seen", 32'(n < 60), 32'd1);
      c = cyc;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: got running expected finished");
      n_errors++;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "timeout");
   end

   initial begin
      int c[4];
      int a0, rb, d;
      bus.core_tx_valid   = 1'b0;
      bus.core_tx_dest    = '0;
      bus.core_tx_payload = '0;
      bus.net_rx_valid    = 1'b0;
      bus.net_rx_data     = '0;
      bus.core_rx_ready   = 1'b0;
      stall_cnt           = 0;
      model_reset();

      // Reset state
      idle(3);
      chk("rst_host_en", 32'(bus.host_en), 32'd0);
      chk("rst_host_data", 32'(bus.host_data_out), 32'd0);
      chk("rst_rx_valid", 32'(bus.core_rx_valid), 32'd0);
      chk("rst_rx_data", 32'(bus.core_rx_data), 32'd0);
      chk("rst_overflow", 32'(bus.rx_overflow), 32'd0);
      chk("rst_counters", {8'd0, bus.tx_count, bus.rx_count, bus.drop_count}, 32'd0);
      rst = 1'b1;
      model_reset();
      model_en = 1'b1;
      #1 chk("tx_ready_after_reset", 32'(bus.core_tx_ready), 32'd1);
      idle(2);

      // Single send: dest 2, payload 0x15 -> packet 0x95 two cycles later
      tx_send(2'd2, 6'h15);
      a0 = last_acc_cyc;
      wait_host_en(c[0]);
      chk("single_latency", 32'(c[0] - a0), 32'd2);
      chk("single_data", 32'(bus.host_data_out), 32'h95);
      idle(3);
      chk("single_tx_count", 32'(bus.tx_count), 32'd1);
      idle(5);

      // Pacing: four back-to-back packets, one injection every 1+GAP cycles
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               tx_send(rand_net_dest(), 6'($urandom));
               if (i == 0) a0 = last_acc_cyc;
            end
         end
         begin
            for (int i = 0; i < 4; i++) wait_host_en(c[i]);
         end
      join
      chk("pace_first_latency", 32'(c[0] - a0), 32'd2);
      for (int i = 1; i < 4; i++) chk("pace_spacing", 32'(c[i] - c[i-1]), 32'(1 + GAP));
      idle(1);

      // TX backpressure once the FIFO fills
      stall_cnt = 0;
      repeat (10) tx_send(rand_net_dest(), 6'($urandom));
      chk("tx_backpressure_seen", 32'(stall_cnt > 0), 32'd1);
      idle(50);

      // RX overflow: five packets into a four-entry FIFO with no pops
      bus.core_rx_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         bus.net_rx_valid = 1'b1;
         bus.net_rx_data  = 8'(i);
         idle(1);
      end
      bus.net_rx_valid = 1'b0;
      idle(1);
      chk("ovf_drop_count", 32'(bus.drop_count), 32'd1);
      chk("ovf_flag", 32'(bus.rx_overflow), 32'd1);
      chk("ovf_head", 32'(bus.core_rx_data), 32'h01);
      bus.core_rx_ready = 1'b1;
      idle(6);
      chk("ovf_drained", 32'(bus.core_rx_valid), 32'd0);

      // Loopback collides with a network delivery
      bus.core_rx_ready = 1'b0;
      rb = bus.rx_count;
      fork
         tx_send(2'(RID), 6'h2A);
         begin
            bus.net_rx_valid = 1'b1;
            bus.net_rx_data  = 8'hC3;
            idle(1);
            bus.net_rx_valid = 1'b0;
         end
      join
      chk("loop_stall_cycles", 32'(last_wait), 32'd1);
      idle(1);
      chk("loop_rx_count", 32'(bus.rx_count - rb), 32'd2);
      chk("loop_first_net", 32'(bus.core_rx_data), 32'hC3);
      bus.core_rx_ready = 1'b1;
      idle(1);
      chk("loop_second_loop", 32'(bus.core_rx_data), 32'h6A);
      idle(3);

      // Randomised mixed traffic
      fork
         repeat (60) tx_send(2'($urandom_range(0, 3)), 6'($urandom));
         begin
            repeat (250) begin
               bus.net_rx_valid = ($urandom_range(0, 1) == 1);
               bus.net_rx_data  = 8'($urandom);
               idle(1);
            end
            bus.net_rx_valid = 1'b0;
         end
         begin
            repeat (250) begin
               bus.core_rx_ready = ($urandom_range(0, 3) != 0);
               idle(1);
            end
            bus.core_rx_ready = 1'b1;
         end
      join
      bus.net_rx_valid  = 1'b0;
      bus.core_rx_ready = 1'b1;
      for (d = 0; d < 100 && (txq.size() + rxq.size()) != 0; d++) idle(1);
      chk("random_all_delivered", 32'(txq.size() + rxq.size()), 32'd0);

      // Saturation: 300 received and drained packets
      repeat (300) begin
         bus.net_rx_valid = 1'b1;
         bus.net_rx_data  = 8'($urandom);
         idle(1);
      end
      bus.net_rx_valid = 1'b0;
      idle(3);
      chk("rx_count_saturated", 32'(bus.rx_count), 32'd255);

      // Asynchronous reset while injecting
      tx_send(rand_net_dest(), 6'($urandom));
      wait_host_en(c[0]);
      #1;
      model_en = 1'b0;
      rst = 1'b0;
      #1;
      chk("midrst_host_en", 32'(bus.host_en), 32'd0);
      chk("midrst_counters", {8'd0, bus.tx_count, bus.rx_count, bus.drop_count}, 32'd0);
      chk("midrst_overflow", 32'(bus.rx_overflow), 32'd0);
      @(posedge clk);
      idle(2);
      rst = 1'b1;
      model_reset();
      model_en = 1'b1;
      #1 chk("midrst_tx_ready", 32'(bus.core_tx_ready), 32'd1);
      chk("midrst_rx_empty", 32'(bus.core_rx_valid), 32'd0);
      idle(10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
